// File: rtl/maj_net_tt_engine_pkg.sv
// Shared types for the majority-network truth-table engine.
// Operand descriptor, FSM state codes and operand-width helper.
package maj_net_pkg;

    localparam int SEL_MAX_W  = 8;
    localparam int SEL_CONST0 = 0;

    typedef struct packed {
        logic                 inv;
        logic [SEL_MAX_W-1:0] sel;
    } operand_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EVAL = 2'd1;
    localparam state_t ST_EMIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic int sel_width(int n_in, int n_gate);
        return $clog2(1 + n_in + n_gate);
    endfunction

endpackage

// File: rtl/maj_net_tt_engine_if.sv
// Truth-table bit stream: one bit per input pattern.
// The engine is master; the consumer drives ready.
interface maj_net_tt_engine_if #(
    parameter int N_IN = 7
) ();
    logic            valid;
    logic            ready;
    logic [N_IN-1:0] idx;
    logic            data;

    modport master (output valid, idx, data, input ready);
    modport slave  (input valid, idx, data, output ready);
endinterface

// File: rtl/maj_net_operand_mux.sv
// Resolves one {inv, sel} operand to a bit value.
// Forward or self gate references and out-of-range selects read as 0.
module maj_net_operand_mux
    import maj_net_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int N_GATE = 8,
    parameter int GW     = 3
) (
    input  operand_t          op,
    input  logic [N_IN-1:0]   pat,
    input  logic [N_GATE-1:0] gv,
    input  logic [GW-1:0]     gidx,
    output logic              val,
    output logic              illegal
);

    logic raw;
    int   s;

    // Select constant, primary input or an earlier gate's value
    always_comb begin
        raw     = 1'b0;
        illegal = 1'b0;
        s       = int'(op.sel);
        if (s == SEL_CONST0) begin
            raw = 1'b0;
        end else if (s <= N_IN) begin
            for (int i = 0; i < N_IN; i++) begin
                if (s == i + 1) raw = pat[i];
            end
        end else if (s <= N_IN + N_GATE) begin
            illegal = 1'b1;
            for (int j = 0; j < N_GATE; j++) begin
                if (s == N_IN + 1 + j && j < int'(gidx)) begin
                    raw     = gv[j];
                    illegal = 1'b0;
                end
            end
        end else begin
            illegal = 1'b1;
        end
        val = raw ^ op.inv;
    end

endmodule

// File: rtl/maj_net_tt_engine.sv
// Majority-gate netlist evaluator: sweeps all input patterns,
// evaluates one gate per cycle and streams the truth table.
module maj_net_tt_engine
    import maj_net_pkg::*;
#(
    parameter  int N_IN   = 7,
    parameter  int N_GATE = 8,
    parameter  int SEL_W  = sel_width(N_IN, N_GATE),
    localparam int AW     = (N_GATE > 1) ? $clog2(N_GATE) : 1,
    localparam int OW     = SEL_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [3*OW-1:0]     cfg_data,
    input  logic                cfg_out_inv,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [N_IN:0]       tt_ones,
    output logic                err,
    maj_net_tt_engine_if.master tt
);

    state_t            state;
    logic [3*OW-1:0]   desc [N_GATE];
    logic [N_GATE-1:0] gv;
    logic [AW-1:0]     g;
    logic [N_IN-1:0]   pat;
    logic              out_inv;

    logic [3*OW-1:0]   cur;
    operand_t          ops [3];
    logic [2:0]        v;
    logic [2:0]        ill;
    logic              maj;
    logic              bit_out;

    assign cur = desc[g];

    // Split the current gate's descriptor into its three operands
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ops[k].inv = cur[k*OW + SEL_W];
            ops[k].sel = SEL_MAX_W'(cur[k*OW +: SEL_W]);
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_mux
        maj_net_operand_mux #(
            .N_IN   (N_IN),
            .N_GATE (N_GATE),
            .GW     (AW)
        ) u_mux (
            .op      (ops[k]),
            .pat     (pat),
            .gv      (gv),
            .gidx    (g),
            .val     (v[k]),
            .illegal (ill[k])
        );
    end

    assign maj     = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    assign bit_out = (state == ST_EMIT) & (gv[N_GATE-1] ^ out_inv);

    assign busy     = (state == ST_EVAL) || (state == ST_EMIT);
    assign done     = (state == ST_DONE);
    assign tt.valid = (state == ST_EMIT);
    assign tt.idx   = pat;
    assign tt.data  = bit_out;

    // Sweep FSM, netlist storage and result accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            for (int i = 0; i < N_GATE; i++) desc[i] <= '0;
            gv      <= '0;
            g       <= '0;
            pat     <= '0;
            tt_ones <= '0;
            err     <= 1'b0;
            out_inv <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_we && int'(cfg_addr) < N_GATE)
                        desc[cfg_addr] <= cfg_data;
                    if (start) begin
                        pat     <= '0;
                        g       <= '0;
                        tt_ones <= '0;
                        err     <= 1'b0;
                        out_inv <= cfg_out_inv;
                        state   <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    gv[g] <= maj;
                    if (|ill) err <= 1'b1;
                    if (int'(g) == N_GATE - 1) state <= ST_EMIT;
                    else g <= g + 1'b1;
                end
                ST_EMIT: begin
                    if (tt.ready) begin
                        tt_ones <= tt_ones + {{N_IN{1'b0}}, bit_out};
                        if (&pat) begin
                            state <= ST_DONE;
                        end else begin
                            pat   <= pat + 1'b1;
                            g     <= '0;
                            state <= ST_EVAL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
